// File: rtl/clk_en_scheduler.sv
// Clock-enable scheduler: one-cycle ce pulses at programmable ratios of clk, with glitch-free start/drain-stop.
// Optional TOGGLE_OUT_EN adds clk_out, a 50%-duty square wave per channel for observation or forwarding.
module clk_en_scheduler #(
    parameter int NCH  = 3,
    parameter int DIVW = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [DIVW-1:0]                        cfg_div,
    input  logic                                   start,
    input  logic                                   stop,
    output logic                                   busy,
`ifdef TOGGLE_OUT_EN
    output logic [NCH-1:0]                         ce,
    output logic [NCH-1:0]                         clk_out
`else
    output logic [NCH-1:0]                         ce
`endif
);

    localparam logic [DIVW-1:0] ONE = {{(DIVW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t          state, state_nxt;
    logic [DIVW-1:0] div     [NCH];
    logic [DIVW-1:0] div_eff [NCH];
    logic [DIVW-1:0] cnt     [NCH];
    logic [DIVW-1:0] cnt_nxt [NCH];
    logic [NCH-1:0]  ce_nxt;
    logic [NCH-1:0]  done;
    logic [NCH-1:0]  drained;
    logic            cfg_fire;

    assign cfg_ready = (state == IDLE);
    assign cfg_fire  = cfg_valid & cfg_ready;

    // A write in the same IDLE cycle as start must already shape the first RUN cycle,
    // so the scheduling logic looks at the ratio as it will be after this edge.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            div_eff[i] = div[i];
            if (cfg_fire && (int'(cfg_ch) == i))
                div_eff[i] = cfg_div;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++)
            drained[i] = (div[i] == '0) | done[i] | ce[i];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = RUN;
            RUN:     if (stop)      state_nxt = STOP;
            STOP:    if (&drained)  state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Counter value for the coming cycle; ce is registered, so it is decoded from cnt_nxt.
    // In STOP a channel that has fired (now or earlier) is masked until IDLE.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
            ce_nxt[i]  = 1'b0;
            if ((state != IDLE) && (state_nxt != IDLE)) begin
                if ((div[i] == '0) || (cnt[i] == div[i] - ONE))
                    cnt_nxt[i] = '0;
                else
                    cnt_nxt[i] = cnt[i] + ONE;
            end
            if ((state_nxt != IDLE) && (div_eff[i] != '0) &&
                (cnt_nxt[i] == div_eff[i] - ONE) &&
                !((state == STOP) && (done[i] | ce[i])))
                ce_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            ce    <= '0;
            done  <= '0;
            for (int i = 0; i < NCH; i++) begin
                div[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            ce    <= ce_nxt;
            done  <= (state == STOP) ? (done | ce) : '0;
            for (int i = 0; i < NCH; i++) begin
                div[i] <= div_eff[i];
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef TOGGLE_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            clk_out <= '0;
        else if (state_nxt == IDLE)
            clk_out <= '0;
        else
            clk_out <= clk_out ^ ce;
    end
`endif

endmodule
